// File: rtl/ws_pkg.sv
// ws_pkg: shared states, element types and latency helper for the weight-stationary engine.
package ws_pkg;
    localparam int DEF_IACT_W   = 32;
    localparam int DEF_WEIGHT_W = 16;
    localparam int DEF_PSUM_W   = 48;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    typedef logic [DEF_IACT_W-1:0]   iact_t;
    typedef logic [DEF_WEIGHT_W-1:0] weight_t;
    typedef logic [DEF_PSUM_W-1:0]   psum_t;

    function automatic int calc_latency(input int rows, input int cols);
        return rows + cols;
    endfunction
endpackage

// File: rtl/ws_delay_line.sv
// ws_delay_line: DEPTH-stage shift register with synchronous reset; DEPTH 0 is a plain wire.
module ws_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    if (DEPTH == 0) begin : g_wire
        assign dout = din;
    end else begin : g_sr
        logic [WIDTH-1:0] sr [DEPTH];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
            end else begin
                sr[0] <= din;
                for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
        end
        assign dout = sr[DEPTH-1];
    end
endmodule

// File: rtl/ws_array_engine.sv
// ws_array_engine: weight-stationary ROWS x COLS systolic array with weight-load FSM,
// input skew, output deskew and a fixed ROWS+COLS cycle latency.
module ws_array_engine
    import ws_pkg::*;
#(
    parameter int ROWS     = 3,
    parameter int COLS     = 3,
    parameter int IACT_W   = 32,
    parameter int WEIGHT_W = 16,
    parameter int PSUM_W   = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [COLS*WEIGHT_W-1:0] w_row,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ROWS*IACT_W-1:0]   a_vec,
    input  logic                     a_last,
    output logic                     p_valid,
    output logic [COLS*PSUM_W-1:0]   p_vec,
    output logic                     p_last,
    output logic                     busy
);
    localparam int L  = calc_latency(ROWS, COLS);
    localparam int IW = $clog2(L + 1);
    localparam int KW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int IC = COLS > 1 ? COLS - 1 : 1;

    state_t          state, state_nx;
    logic [KW-1:0]   k, k_nx, w_sel;
    logic            w_fire, a_fire, ov, ol;
    logic [IW-1:0]   inflight;
    logic [WEIGHT_W-1:0] weight_reg [ROWS][COLS];
    logic [IACT_W-1:0]   iact_reg   [ROWS][IC];
    logic [PSUM_W-1:0]   psum_reg   [ROWS][COLS];
    logic [1:0]          tag_reg    [ROWS][COLS];
    logic [IACT_W-1:0]   skew_out   [ROWS];
    logic [PSUM_W+1:0]   dsk_out    [COLS];

    always_comb begin
        w_ready  = state != RUN || (inflight == '0 && !a_valid);
        a_ready  = state == RUN;
        w_fire   = w_valid && w_ready;
        a_fire   = a_valid && a_ready;
        w_sel    = state == LOAD ? k : '0;
        k_nx     = k;
        state_nx = state;
        if (w_fire) begin
            k_nx     = state == LOAD ? k + 1'b1 : KW'(1);
            state_nx = (ROWS == 1 || (state == LOAD && k == KW'(ROWS - 1))) ? RUN : LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
        end
    end

    // Weights only change with the array empty, so no in-flight vector sees a mix.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) weight_reg[r][c] <= '0;
        end else if (w_fire) begin
            for (int c = 0; c < COLS; c++) weight_reg[w_sel][c] <= w_row[c*WEIGHT_W +: WEIGHT_W];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        if (r == 0) begin : g_w
            assign skew_out[r] = a_vec[IACT_W-1:0];
        end else begin : g_d
            ws_delay_line #(.DEPTH(r), .WIDTH(IACT_W)) u_dl (
                .clk(clk), .rst(rst), .din(a_vec[r*IACT_W +: IACT_W]), .dout(skew_out[r])
            );
        end
    end

    // {valid, last} enters at PE(0,0), walks right along row 0, then down each column with its psum.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [IACT_W-1:0]          ai;
            logic [PSUM_W-1:0]          pi;
            logic [1:0]                 ti;
            logic [IACT_W+WEIGHT_W-1:0] prod;
            if (c == 0) begin : g_ai0
                assign ai = skew_out[r];
            end else begin : g_ain
                assign ai = iact_reg[r][c-1];
            end
            if (r == 0) begin : g_pi0
                assign pi = '0;
            end else begin : g_pin
                assign pi = psum_reg[r-1][c];
            end
            if (r == 0 && c == 0) begin : g_t0
                assign ti = {a_fire, a_fire && a_last};
            end else if (r == 0) begin : g_tr
                assign ti = tag_reg[0][c-1];
            end else begin : g_td
                assign ti = tag_reg[r-1][c];
            end
            assign prod = {{WEIGHT_W{1'b0}}, ai} * {{IACT_W{1'b0}}, weight_reg[r][c]};
            if (c < COLS - 1) begin : g_fwd
                always_ff @(posedge clk) iact_reg[r][c] <= rst ? '0 : ai;
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    psum_reg[r][c] <= '0;
                    tag_reg[r][c]  <= '0;
                end else begin
                    psum_reg[r][c] <= pi + PSUM_W'(prod);
                    tag_reg[r][c]  <= ti;
                end
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_dsk
        if (c == COLS - 1) begin : g_w
            assign dsk_out[c] = {tag_reg[ROWS-1][c], psum_reg[ROWS-1][c]};
        end else begin : g_d
            ws_delay_line #(.DEPTH(COLS - 1 - c), .WIDTH(PSUM_W + 2)) u_dl (
                .clk(clk), .rst(rst), .din({tag_reg[ROWS-1][c], psum_reg[ROWS-1][c]}), .dout(dsk_out[c])
            );
        end
    end

    always_comb begin
        ov = 1'b0;
        ol = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            ov = ov | dsk_out[c][PSUM_W+1];
            ol = ol | dsk_out[c][PSUM_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid  <= 1'b0;
            p_last   <= 1'b0;
            p_vec    <= '0;
            inflight <= '0;
        end else begin
            p_valid  <= ov;
            p_last   <= ov && ol;
            inflight <= inflight + IW'(a_fire) - IW'(p_valid);
            if (ov)
                for (int c = 0; c < COLS; c++) p_vec[c*PSUM_W +: PSUM_W] <= dsk_out[c][PSUM_W-1:0];
        end
    end

    assign busy = state != IDLE || inflight != '0;
endmodule

// File: tb/tb_ws_array_engine.sv
// tb_ws_array_engine: directed and randomized checks of ws_array_engine against a
// matrix-vector reference model with a due-cycle scoreboard.
module tb_ws_array_engine;
    localparam int R = 3, C = 3, AW = 32, WW = 16, PW = 48, L = R + C;

    logic            clk = 1'b0, rst = 1'b1;
    logic            w_valid = 1'b0, a_valid = 1'b0, a_last = 1'b0;
    logic [C*WW-1:0] w_row = '0;
    logic [R*AW-1:0] a_vec = '0;
    logic            w_ready, a_ready, p_valid, p_last, busy;
    logic [C*PW-1:0] p_vec;

    int errors = 0, checks = 0, ncyc = 0;

    ws_array_engine #(.ROWS(R), .COLS(C), .IACT_W(AW), .WEIGHT_W(WW), .PSUM_W(PW)) dut (
        .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
        .a_valid(a_valid), .a_ready(a_ready), .a_vec(a_vec), .a_last(a_last),
        .p_valid(p_valid), .p_vec(p_vec), .p_last(p_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [C*PW-1:0] got, input logic [C*PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    function automatic logic [C*WW-1:0] mk_w(input int e0, input int e1, input int e2);
        return {WW'(e2), WW'(e1), WW'(e0)};
    endfunction

    function automatic logic [R*AW-1:0] mk_a(input int unsigned e0, input int unsigned e1, input int unsigned e2);
        return {AW'(e2), AW'(e1), AW'(e0)};
    endfunction

    function automatic logic [C*PW-1:0] mk_p(input logic [PW-1:0] e0, input logic [PW-1:0] e1, input logic [PW-1:0] e2);
        return {e2, e1, e0};
    endfunction

    // Reference model: weight matrix, load progress, phase, and expected outputs with due cycles.
    typedef struct {
        int              due;
        logic [C*PW-1:0] p;
        logic            last;
    } exp_t;

    logic [WW-1:0] mw [R][C];
    int            wk = 0, mst = 0;
    bit            armed = 0, exp_v, m_w_ready, m_a_ready;
    exp_t          q[$];

    function automatic logic [C*PW-1:0] mvm(input logic [R*AW-1:0] a);
        logic [C*PW-1:0]   p;
        logic [PW-1:0]     acc;
        longint unsigned   x, y;
        p = '0;
        for (int c = 0; c < C; c++) begin
            acc = '0;
            for (int r = 0; r < R; r++) begin
                x   = a[r*AW +: AW];
                y   = mw[r][c];
                acc = acc + PW'(x * y);
            end
            p[c*PW +: PW] = acc;
        end
        return p;
    endfunction

    always @(negedge clk) begin
        ncyc++;
        m_a_ready = mst == 2;
        m_w_ready = mst != 2 || (q.size() == 0 && !a_valid);
        if (armed) begin
            exp_v = q.size() != 0 && q[0].due == ncyc;
            chk("p_valid", p_valid, exp_v);
            chk("a_ready", a_ready, m_a_ready);
            chk("w_ready", w_ready, m_w_ready);
            chk("busy", busy, mst != 0 || q.size() != 0);
            if (exp_v) begin
                chk("p_vec", p_vec, q[0].p);
                chk("p_last", p_last, q[0].last);
                void'(q.pop_front());
            end
        end
        if (rst) begin
            q.delete();
            mst   = 0;
            wk    = 0;
            armed = 1;
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) mw[r][c] = '0;
        end else begin
            if (a_valid && m_a_ready) q.push_back('{due: ncyc + L, p: mvm(a_vec), last: a_last});
            if (w_valid && m_w_ready) begin
                for (int c = 0; c < C; c++) mw[wk][c] = w_row[c*WW +: WW];
                wk  = (wk + 1) % R;
                mst = wk == 0 ? 2 : 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_w(input logic [C*WW-1:0] row);
        int n = 0;
        w_valid = 1'b1;
        w_row   = row;
        while (!w_ready && n < 100) begin
            step();
            n++;
        end
        chk("w_handshake_timeout", n >= 100, 1'b0);
        step();
        w_valid = 1'b0;
    endtask

    task automatic send_a(input logic [R*AW-1:0] v, input logic last, output int t);
        int n = 0;
        a_valid = 1'b1;
        a_vec   = v;
        a_last  = last;
        while (!a_ready && n < 100) begin
            step();
            n++;
        end
        chk("a_handshake_timeout", n >= 100, 1'b0);
        step();
        t       = ncyc;
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    task automatic wait_p(output int t);
        int n = 0;
        while (!p_valid && n < 40) begin
            step();
            n++;
        end
        chk("p_valid_timeout", n >= 40, 1'b0);
        t = ncyc;
    endtask

    task automatic load_basic();
        send_w(mk_w(9, 8, 7));
        send_w(mk_w(6, 5, 4));
        send_w(mk_w(3, 2, 1));
    endtask

    task automatic basic_stream(input string tag);
        int t0, t;
        send_a(mk_a(1, 2, 3), 1'b0, t0);
        send_a(mk_a(4, 5, 6), 1'b0, t);
        send_a(mk_a(7, 8, 9), 1'b1, t);
        wait_p(t);
        chk({tag, "_latency"}, C*PW'(t - t0), C*PW'(L - 1));
        chk({tag, "_p0"}, p_vec, mk_p(30, 24, 18));
        chk({tag, "_last0"}, p_last, 1'b0);
        step();
        chk({tag, "_p1"}, p_vec, mk_p(84, 69, 54));
        chk({tag, "_last1"}, p_last, 1'b0);
        step();
        chk({tag, "_p2"}, p_vec, mk_p(138, 114, 90));
        chk({tag, "_last2"}, p_last, 1'b1);
        step();
        chk({tag, "_drained"}, p_valid, 1'b0);
    endtask

    initial begin
        int t;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_p_valid", p_valid, 1'b0);
        chk("rst_p_last", p_last, 1'b0);
        chk("rst_p_vec", p_vec, '0);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_w_ready", w_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);

        load_basic();
        basic_stream("basic");

        send_a(mk_a(1, 0, 0), 1'b0, t);
        step();
        step();
        send_a(mk_a(0, 0, 1), 1'b0, t);
        wait_p(t);
        chk("bubble_p0", p_vec, mk_p(9, 8, 7));
        step();
        chk("bubble_gap0", p_valid, 1'b0);
        step();
        chk("bubble_gap1", p_valid, 1'b0);
        step();
        chk("bubble_p1_valid", p_valid, 1'b1);
        chk("bubble_p1", p_vec, mk_p(3, 2, 1));
        step();

        w_valid = 1'b1;
        w_row   = mk_w(1, 0, 0);
        for (int i = 0; i < 4; i++) send_a(mk_a(i + 1, 2 * i, 3), 1'b0, t);
        chk("reload_blocked", w_ready, 1'b0);
        send_w(mk_w(1, 0, 0));
        send_w(mk_w(0, 1, 0));
        send_w(mk_w(0, 0, 1));
        send_a(mk_a(5, 6, 7), 1'b1, t);
        wait_p(t);
        chk("reload_identity", p_vec, mk_p(5, 6, 7));
        step();

        a_valid = 1'b1;
        a_vec   = mk_a(2, 3, 4);
        w_valid = 1'b1;
        w_row   = mk_w(7, 7, 7);
        #1;
        chk("simul_w_ready", w_ready, 1'b0);
        chk("simul_a_ready", a_ready, 1'b1);
        step();
        a_valid = 1'b0;
        w_valid = 1'b0;
        wait_p(t);
        chk("simul_identity_kept", p_vec, mk_p(2, 3, 4));
        step();

        for (int i = 0; i < R; i++) send_w(mk_w(16'hFFFF, 16'hFFFF, 16'hFFFF));
        send_a(mk_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b1, t);
        wait_p(t);
        // 3*(2^48-2^32-2^16+1) mod 2^48
        chk("wrap", p_vec, mk_p(48'hFFFC_FFFD_0003, 48'hFFFC_FFFD_0003, 48'hFFFC_FFFD_0003));
        step();

        load_basic();
        send_a(mk_a(1, 2, 3), 1'b0, t);
        send_a(mk_a(4, 5, 6), 1'b0, t);
        send_a(mk_a(7, 8, 9), 1'b1, t);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) chk("rst_weight_reg", dut.weight_reg[r][c], '0);
        chk("rst_mid_busy", busy, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("rst_mid_no_p_valid", p_valid, 1'b0);
            step();
        end
        load_basic();
        basic_stream("after_rst");

        for (int i = 0; i < 600; i++) begin
            int mode = (i / 60) % 3;
            a_valid = mode == 0 ? ($urandom % 4 != 0) : mode == 1 ? ($urandom % 4 == 0) : ($urandom % 2 == 0);
            a_last  = $urandom % 4 == 0;
            for (int r = 0; r < R; r++) a_vec[r*AW +: AW] = $urandom;
            w_valid = $urandom % (mode == 1 ? 2 : 6) == 0;
            for (int c = 0; c < C; c++) w_row[c*WW +: WW] = ($urandom % 3 == 0) ? 16'hFFFF : WW'($urandom);
            rst = $urandom % 250 == 0;
            step();
        end
        rst     = 1'b0;
        a_valid = 1'b0;
        w_valid = 1'b0;
        repeat (L + 3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
